load_store_unit: RTL and testbench

- Sits between the CPU datapath's memory stage and data_memory.
- Accepts byte-addressed load/store requests of byte, halfword or word size, and converts them into word-indexed accesses on data_memory's rd/wr/addr/data_in/data_out port.
- Sub-word stores are done as a read-modify-write, because data_memory only writes whole words.
- Provides a ready/done handshake, sign/zero extension of loads, and flags misaligned or out-of-range accesses.

---
 rtl/ls_pkg.sv | 28 ++
 rtl/ls_lane_align.sv | 56 +++++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access size codes,
// and the alignment rule for sub-word accesses.
package ls_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Halfwords must sit on an even byte, words on a word boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Combinational lane steering: extracts and extends a byte/half/word for loads, and merges
// store data into the fetched word for read-modify-write stores (little-endian).
module ls_lane_align
    import ls_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic [1:0]            lane,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [WORD_WIDTH-1:0] word,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic [WORD_WIDTH-1:0] merged
);

    logic [4:0]            shamt;
    logic [WORD_WIDTH-1:0] shifted;
    logic [7:0]            byte_val;
    logic [15:0]           half_val;
    logic [WORD_WIDTH-1:0] mask;
    logic [WORD_WIDTH-1:0] ins;

    always_comb begin
        shamt    = {lane, 3'b000};
        shifted  = word >> shamt;
        byte_val = shifted[7:0];
        half_val = shifted[15:0];

        rdata = word;
        case (size)
            SZ_BYTE: rdata = {{(WORD_WIDTH-8){sign_ext & byte_val[7]}}, byte_val};
            SZ_HALF: rdata = {{(WORD_WIDTH-16){sign_ext & half_val[15]}}, half_val};
            default: rdata = word;
        endcase

        mask = '1;
        ins  = wdata;
        case (size)
            SZ_BYTE: begin
                mask = {{(WORD_WIDTH-8){1'b0}}, 8'hFF} << shamt;
                ins  = {{(WORD_WIDTH-8){1'b0}}, wdata[7:0]} << shamt;
            end
            SZ_HALF: begin
                mask = {{(WORD_WIDTH-16){1'b0}}, 16'hFFFF} << shamt;
                ins  = {{(WORD_WIDTH-16){1'b0}}, wdata[15:0]} << shamt;
            end
            default: begin
                mask = '1;
                ins  = wdata;
            end
        endcase
        merged = (word & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-only data memory. Sub-word stores are done
// as read-modify-write; bad accesses complete immediately with err and never touch memory.
module load_store_unit
    import ls_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [WORD_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic [WORD_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_din,
    input  logic [WORD_WIDTH-1:0] mem_dout,
    output logic                  mem_rd,
    output logic                  mem_wr
);

    localparam logic [WORD_WIDTH-1:0] MemWordsW = WORD_WIDTH'(MEM_WORDS);

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  sext_q, sext_d;
    logic [1:0]            lane_q, lane_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic [WORD_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;

    logic [WORD_WIDTH-1:0] word_idx;
    logic                  bad_req;
    logic [WORD_WIDTH-1:0] align_rdata;
    logic [WORD_WIDTH-1:0] align_merged;

    ls_lane_align #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_align (
        .lane    (lane_q),
        .size    (size_q),
        .sign_ext(sext_q),
        .word    (mem_dout),
        .wdata   (wdata_q),
        .rdata   (align_rdata),
        .merged  (align_merged)
    );

    assign word_idx = {2'b00, addr[WORD_WIDTH-1:2]};
    assign bad_req  = (size == 2'b11) || is_misaligned(size, addr[1:0]) ||
                      (word_idx >= MemWordsW);

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        sext_d     = sext_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d       = we;
                    size_d     = size;
                    sext_d     = sign_ext;
                    lane_d     = addr[1:0];
                    wdata_d    = wdata;
                    mem_addr_d = word_idx;
                    if (bad_req) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (!we || size != SZ_WORD) begin
                        err_d    = 1'b0;
                        mem_rd_d = 1'b1;
                        state_d  = READ;
                    end else begin
                        err_d     = 1'b0;
                        mem_wr_d  = 1'b1;
                        mem_din_d = wdata;
                        state_d   = WRITE;
                    end
                end
            end
            READ: begin
                // mem_dout is valid this cycle; consume it directly rather than re-reading.
                if (we_q) begin
                    mem_wr_d  = 1'b1;
                    mem_din_d = align_merged;
                    state_d   = WRITE;
                end else begin
                    rdata_d = align_rdata;
                    state_d = DONE;
                end
            end
            WRITE: state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            sext_q     <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign ready    = (state_q == IDLE);
    assign done     = (state_q == DONE);
    assign err      = (state_q == DONE) && err_q;
    assign rdata    = rdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit with a 512-word behavioural data memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst, req, we, sign_ext, init;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready, done, err, mem_rd, mem_wr;
    logic [31:0] rdata, mem_addr, mem_din, mem_dout;
    logic [31:0] mem [0:511];

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        logic        chk;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    load_store_unit #(
        .WORD_WIDTH(32),
        .MEM_WORDS (512)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .size    (size),
        .sign_ext(sign_ext),
        .addr    (addr),
        .wdata   (wdata),
        .ready   (ready),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .mem_addr(mem_addr),
        .mem_din (mem_din),
        .mem_dout(mem_dout),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr)
    );

    always #5 clk = ~clk;

    assign mem_dout = (mem_addr < 32'd512) ? mem[mem_addr[8:0]] : 32'h0;

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
            mem[4] <= 32'hA1B2C3D4;
        end else if (mem_wr && mem_addr < 32'd512) begin
            mem[mem_addr[8:0]] <= mem_din;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected no pending transaction");
            end else begin
                e = q.pop_front();
                check({e.name, "_err"}, {31'h0, err}, {31'h0, e.err});
                if (e.chk) check({e.name, "_rdata"}, rdata, e.rdata);
            end
        end
    end

    // One transaction; cycle numbers count from the accept edge (0 means never seen).
    task automatic txn(input string name, input logic w, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input int rd_cyc, input int wr_cyc, input int done_cyc,
                       input logic [31:0] din, input logic xerr, input logic [31:0] xrd,
                       input logic chk);
        int          rd_c, wr_c, dn_c;
        logic [31:0] din_seen;
        exp_t        x;
        x.name = name; x.err = xerr; x.rdata = xrd; x.chk = chk;
        q.push_back(x);
        @(negedge clk);
        check({name, "_ready"}, {31'h0, ready}, 32'h1);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        rd_c = 0; wr_c = 0; dn_c = 0; din_seen = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (mem_rd) rd_c = (rd_c == 0) ? c : 99;
            if (mem_wr) begin
                wr_c     = (wr_c == 0) ? c : 99;
                din_seen = mem_din;
            end
            if (done) dn_c = (dn_c == 0) ? c : 99;
        end
        check({name, "_rd_cycle"}, rd_c, rd_cyc);
        check({name, "_wr_cycle"}, wr_c, wr_cyc);
        check({name, "_done_cycle"}, dn_c, done_cyc);
        if (wr_cyc != 0) check({name, "_mem_din"}, din_seen, din);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd_mask, wr_mask, dn_mask;
        exp_t        x;
        init = 1'b1; rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        init = 1'b0; rst = 1'b0;

        check("reset_ready", {31'h0, ready}, 32'h1);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_din", mem_din, 32'h0);
        check("reset_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("reset_mem_wr", {31'h0, mem_wr}, 32'h0);

        txn("ld_byte_sx", 0, 2'b00, 1, 32'h11, 0, 1, 0, 2, 0, 0, 32'hFFFFFFC3, 1);
        txn("ld_half_zx", 0, 2'b01, 0, 32'h12, 0, 1, 0, 2, 0, 0, 32'h0000A1B2, 1);
        txn("st_byte", 1, 2'b00, 0, 32'h13, 32'h5A, 1, 2, 3, 32'h5AB2C3D4, 0, 0, 0);
        check("mem4_after_st_byte", mem[4], 32'h5AB2C3D4);
        txn("ld_word", 0, 2'b10, 1, 32'h10, 0, 1, 0, 2, 0, 0, 32'h5AB2C3D4, 1);
        txn("st_word", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 1, 2, 32'hDEADBEEF, 0, 0, 0);
        check("mem4_after_st_word", mem[4], 32'hDEADBEEF);
        txn("st_half", 1, 2'b01, 0, 32'h12, 32'hCAFE1234, 1, 2, 3, 32'h1234BEEF, 0, 0, 0);
        txn("ld_byte0_sx", 0, 2'b00, 1, 32'h10, 0, 1, 0, 2, 0, 0, 32'hFFFFFFEF, 1);
        txn("ld_byte3_zx", 0, 2'b00, 0, 32'h13, 0, 1, 0, 2, 0, 0, 32'h00000012, 1);
        txn("err_misalign", 0, 2'b01, 0, 32'h11, 0, 0, 0, 1, 0, 1, 0, 0);
        txn("err_range", 0, 2'b10, 0, 32'h800, 0, 0, 0, 1, 0, 1, 0, 0);
        txn("err_size", 0, 2'b11, 0, 32'h10, 0, 0, 0, 1, 0, 1, 0, 0);
        txn("err_st_misalign", 1, 2'b10, 0, 32'h12, 32'h1, 0, 0, 1, 0, 1, 0, 0);
        check("mem4_after_errors", mem[4], 32'h1234BEEF);

        // Reset during the READ of a sub-word store must abort it silently.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h77;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("rst_mid_in_read", {31'h0, mem_rd}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", {31'h0, ready}, 32'h1);
        check("rst_mid_mem_rd", {31'h0, mem_rd}, 32'h0);
        wr_mask = 0; dn_mask = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_wr) wr_mask[c] = 1'b1;
            if (done) dn_mask[c] = 1'b1;
            @(negedge clk);
        end
        check("rst_mid_no_wr", wr_mask, 32'h0);
        check("rst_mid_no_done", dn_mask, 32'h0);
        check("rst_mid_mem4", mem[4], 32'h1234BEEF);

        // req held high: ignored while busy, accepted again the cycle after DONE.
        x.name = "held_first"; x.err = 1'b0; x.rdata = 32'h1234BEEF; x.chk = 1'b1;
        q.push_back(x);
        x.name = "held_second";
        q.push_back(x);
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h0;
        @(posedge clk);
        rd_mask = 0; wr_mask = 0; dn_mask = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 4) req = 1'b0;
            if (mem_rd) rd_mask[c] = 1'b1;
            if (mem_wr) wr_mask[c] = 1'b1;
            if (done) dn_mask[c] = 1'b1;
        end
        check("held_rd_cycles", rd_mask, 32'h12);
        check("held_done_cycles", dn_mask, 32'h24);
        check("held_no_wr", wr_mask, 32'h0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
